instr_issuer: RTL and testbench
===============================

// Module: instr_issuer
// PURPOSE
//  Initiator side of the processor control interface (w/func/rx/ry/data in, curr_state out).
//  Holds a small loadable program memory and issues one instruction at a time.
//  Pulses w with func/rx/ry/data, then tracks curr_state through the issue/return-to-idle handshake.
//  Sits between the test/host fabric and the processor control block.
// PARAMETERS
//  DEPTH       16     program words (power of 2); AW = $clog2(DEPTH)
//  FUNC_W      3      opcode width
//  REG_W       4      rx/ry register-select width
//  DATA_W      4      immediate data width
//  IDLE_STATE  5'd0   processor curr_state encoding meaning "idle, ready for w"
//  TIMEOUT     63     max cycles in any wait state (watchdog only)
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  load_we     in   1      write load_word at load_addr (ignored while busy)
//  load_addr   in   AW     program write address
//  load_word   in   IW     {func,rx,ry,data}; IW = FUNC_W+2*REG_W+DATA_W (15)
//  prog_len    in   AW+1   number of instructions to run, sampled on start; 0 = none
//  start       in   1      begin run at address 0 (ignored while busy)
//  curr_state  in   5      processor FSM state
//  w           out  1      instruction-valid pulse to processor
//  func        out  FUNC_W opcode to processor
//  rx, ry      out  REG_W  register selects to processor
//  data        out  DATA_W immediate to processor
//  busy        out  1      run in progress
//  done        out  1      one-cycle pulse when run completes
//  pc          out  AW+1   index of the instruction currently issued
//  err         out  1      sticky watchdog error (tied 0 without WATCHDOG_EN)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, pc=0, err=0. Program memory is not cleared.
//  Reset mid-run aborts immediately; no done pulse is produced.
//  States:
//   IDLE: start & prog_len!=0 -> FETCH, busy=1, pc=0.
//         start & prog_len==0 -> done pulse next cycle, stay IDLE.
//   FETCH: register mem[pc] into func/rx/ry/data (1-cycle read latency) -> ISSUE.
//   ISSUE: if curr_state==IDLE_STATE, w=1 for exactly one cycle -> WAIT_ACK; else hold.
//   WAIT_ACK: curr_state!=IDLE_STATE -> WAIT_DONE.
//   WAIT_DONE: curr_state==IDLE_STATE -> NEXT.
//   NEXT: pc+1==len_q -> IDLE, done=1, busy=0; else pc+=1 -> FETCH.
//  func/rx/ry/data stay stable from FETCH until the next FETCH.
//  Minimum per-instruction overhead: 4 cycles plus processor execution time.
//  pc is AW+1 wide, so prog_len==DEPTH runs all words with no wrap.
//  load_we during busy is dropped.
//  start and load_we in the same IDLE cycle: the write happens; the run starts using old contents at addr 0 only if load_addr!=0.
// CONFIGURATION
//  WATCHDOG_EN defined: a counter resets on each state entry and counts in ISSUE/WAIT_ACK/WAIT_DONE.
//   Reaching TIMEOUT sets err (sticky until rst), goes to IDLE, busy=0, and gives no done pulse.
//  WATCHDOG_EN undefined: no counter, err tied 0, waits are unbounded.
// STRUCTURE
//  Package instr_issuer_pkg: state enum {IDLE,FETCH,ISSUE,WAIT_ACK,WAIT_DONE,NEXT}, word field offsets, IW.
//  Sub-module prog_ram (DEPTH x IW, sync write, registered read).
//  FSM and datapath live in the top module.
// TESTING
//  1. Load 3 words, prog_len=3, start; processor model goes idle->busy (2 cyc)->idle.
//     -> three one-cycle w pulses with matching fields; done once; pc 0,1,2.
//  2. prog_len=0, start -> no w pulse; done pulse 1 cycle after start; busy stays 0.
//  3. curr_state held !=0 when entering ISSUE for 10 cycles.
//     -> w stays 0; w pulses the cycle after curr_state returns to 0.
//  4. Assert rst during WAIT_DONE of instruction 2 of 4 -> next cycle all outputs 0, no done.
//     A restart runs from pc=0.
//  5. WATCHDOG_EN, TIMEOUT=63, processor never leaves idle after w.
//     -> err=1 at 63 cycles; busy=0; no done. Without the macro, busy stays 1.
//  6. prog_len=16 (DEPTH) with distinct words -> all 16 issued in order; done after word 15; no wrap.

Source files
------------

// File: rtl/instr_issuer_pkg.sv
// Shared types and instruction word layout for the instruction issuer.
// Word layout, MSB to LSB: {func, rx, ry, data}.
package instr_issuer_pkg;

    localparam int FUNC_W   = 3;
    localparam int REG_W    = 4;
    localparam int DATA_W   = 4;
    localparam int IW       = FUNC_W + 2 * REG_W + DATA_W;

    localparam int DATA_LSB = 0;
    localparam int RY_LSB   = DATA_LSB + DATA_W;
    localparam int RX_LSB   = RY_LSB + REG_W;
    localparam int FUNC_LSB = RX_LSB + REG_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } state_t;

endpackage

// File: rtl/instr_issuer_prog_ram.sv
// Program store: synchronous write, registered read with read enable.
// The read register holds its value between reads so it can drive the issue fields directly.
module prog_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 15,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Issues a loaded program one instruction at a time over the w/func/rx/ry/data handshake.
// Optional watchdog on the wait states is enabled by defining WATCHDOG_EN.
//
// state     | meaning
// IDLE      | no run; accepts program loads and start
// FETCH     | program word at pc is read into the issue fields
// ISSUE     | waiting for processor idle, then raises w for one cycle
// WAIT_ACK  | waiting for processor to leave idle
// WAIT_DONE | waiting for processor to return to idle
// NEXT      | advance pc or finish the run
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int         DEPTH      = 16,
    parameter logic [4:0] IDLE_STATE = 5'd0,
    parameter int         TIMEOUT    = 63,
    parameter int         AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [IW-1:0]     load_word,
    input  logic [AW:0]       prog_len,
    input  logic              start,
    input  logic [4:0]        curr_state,
    output logic              w,
    output logic [FUNC_W-1:0] func,
    output logic [REG_W-1:0]  rx,
    output logic [REG_W-1:0]  ry,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       pc,
    output logic              err
);

    localparam logic [AW:0] PC_ONE = (AW + 1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   pc_q, len_q;
    logic          w_q, done_q;
    logic          start_run, start_empty, advance, finish;
    logic          wd_expire;
    logic          proc_idle, last_instr;
    logic [IW-1:0] word;

    assign proc_idle  = (curr_state == IDLE_STATE);
    assign last_instr = ((pc_q + PC_ONE) == len_q);

    prog_ram #(
        .DEPTH (DEPTH),
        .W     (IW),
        .AW    (AW)
    ) u_prog_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (load_we && (state_q == IDLE)),
        .waddr (load_addr),
        .wdata (load_word),
        .re    (state_q == FETCH),
        .raddr (pc_q[AW-1:0]),
        .rdata (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_run   = 1'b0;
        start_empty = 1'b0;
        advance     = 1'b0;
        finish      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (prog_len != '0) begin
                        start_run = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        start_empty = 1'b1;
                    end
                end
            end
            FETCH:     state_d = ISSUE;
            ISSUE:     if (proc_idle)  state_d = WAIT_ACK;
            WAIT_ACK:  if (!proc_idle) state_d = WAIT_DONE;
            WAIT_DONE: if (proc_idle)  state_d = NEXT;
            NEXT: begin
                if (last_instr) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                    state_d = FETCH;
                end
            end
            default:   state_d = IDLE;
        endcase
        // Expiry only fires while stalled, so it never competes with a real transition.
        if (wd_expire) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            len_q  <= '0;
            w_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            w_q    <= (state_q == ISSUE) && proc_idle;
            done_q <= finish || start_empty;
            if (start_run) begin
                pc_q  <= '0;
                len_q <= prog_len;
            end else if (advance) begin
                pc_q <= pc_q + PC_ONE;
            end
        end
    end

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            stalled;
    logic            err_q;

    assign stalled = ((state_q == ISSUE)     && !proc_idle) ||
                     ((state_q == WAIT_ACK)  &&  proc_idle) ||
                     ((state_q == WAIT_DONE) && !proc_idle);
    assign wd_expire = stalled && (wd_cnt == '0);

    // Down-counter reloads whenever the FSM is not sitting in a wait state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= WD_W'(TIMEOUT - 1);
            err_q  <= 1'b0;
        end else begin
            if (!stalled) begin
                wd_cnt <= WD_W'(TIMEOUT - 1);
            end else if (wd_cnt != '0) begin
                wd_cnt <= wd_cnt - WD_W'(1);
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    assign w    = w_q;
    assign func = word[FUNC_LSB +: FUNC_W];
    assign rx   = word[RX_LSB +: REG_W];
    assign ry   = word[RY_LSB +: REG_W];
    assign data = word[DATA_LSB +: DATA_W];
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign pc   = pc_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer with a small reactive processor model.
module tb_instr_issuer;
    import instr_issuer_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_we;
    logic [AW-1:0]     load_addr;
    logic [IW-1:0]     load_word;
    logic [AW:0]       prog_len;
    logic              start;
    logic [4:0]        curr_state = 5'd0;
    logic              w;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rx, ry;
    logic [DATA_W-1:0] data;
    logic              busy, done, err;
    logic [AW:0]       pc;

    instr_issuer dut (
        .clk        (clk),
        .rst        (rst),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_word  (load_word),
        .prog_len   (prog_len),
        .start      (start),
        .curr_state (curr_state),
        .w          (w),
        .func       (func),
        .rx         (rx),
        .ry         (ry),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] f;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] d;
        logic [4:0] p;
    } rec_t;

    typedef struct {
        logic [14:0] word;
        logic [2:0]  f;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [3:0]  d;
    } vec_t;

    rec_t recs[$];
    int   done_cnt = 0;
    int   dbl_w    = 0;
    logic w_prev   = 1'b0;
    int   errors   = 0;
    int   checks   = 0;

    always @(negedge clk) begin
        if (w) recs.push_back('{func, rx, ry, data, pc});
        if (w && w_prev) dbl_w++;
        if (done) done_cnt++;
        w_prev = w;
    end

    // Processor model: after seeing w it is busy for two cycles, then idle again.
    bit   hold_busy = 1'b0;
    bit   stuck     = 1'b0;
    int   proc_cnt  = 0;
    logic w_seen    = 1'b0;

    always @(negedge clk) w_seen = w;

    always @(posedge clk) begin
        #1;
        if (w_seen && !stuck) proc_cnt = 2;
        else if (proc_cnt > 0) proc_cnt--;
        curr_state = hold_busy ? 5'd7 : ((proc_cnt > 0) ? 5'd3 : 5'd0);
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int a, input logic [14:0] wd);
        load_we   = 1'b1;
        load_addr = a[AW-1:0];
        load_word = wd;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(ok), 32'd1);
        tick();
    endtask

    task automatic run(input int len, input int budget);
        prog_len = len[AW:0];
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(budget);
    endtask

    task automatic check_rec(input string tag, input int idx, input vec_t v, input int exp_pc);
        check({tag, "_func"}, 32'(recs[idx].f), 32'(v.f));
        check({tag, "_rx"},   32'(recs[idx].x), 32'(v.x));
        check({tag, "_ry"},   32'(recs[idx].y), 32'(v.y));
        check({tag, "_data"}, 32'(recs[idx].d), 32'(v.d));
        check({tag, "_pc"},   32'(recs[idx].p), 32'(exp_pc));
    endtask

    initial begin
        vec_t tbl[4];
        int   base, d0, n;
        bit   found;

        tbl[0] = '{15'b101_0011_1100_0110, 3'd5, 4'd3,  4'd12, 4'd6};
        tbl[1] = '{15'b010_1001_0000_1111, 3'd2, 4'd9,  4'd0,  4'd15};
        tbl[2] = '{15'b111_1111_0101_0001, 3'd7, 4'd15, 4'd5,  4'd1};
        tbl[3] = '{15'b000_0110_1010_0011, 3'd0, 4'd6,  4'd10, 4'd3};

        rst = 1'b1; load_we = 1'b0; start = 1'b0;
        load_addr = '0; load_word = '0; prog_len = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_w",    32'(w),    32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pc",   32'(pc),   32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_word", {17'd0, func, rx, ry, data}, 32'd0);
        rst = 1'b0;
        tick();

        // Three-instruction run
        for (int i = 0; i < 3; i++) load(i, tbl[i].word);
        base = recs.size(); d0 = done_cnt;
        run(3, 200);
        check("t1_wcount", 32'(recs.size() - base), 32'd3);
        if (recs.size() - base == 3)
            for (int i = 0; i < 3; i++) check_rec("t1", base + i, tbl[i], i);
        check("t1_done_once", 32'(done_cnt - d0), 32'd1);
        check("t1_single_w",  32'(dbl_w), 32'd0);
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'd0);
        tick();

        // Load while busy must be dropped
        base = recs.size();
        prog_len = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        load_we = 1'b1; load_addr = 4'd1; load_word = 15'h7fff;
        tick();
        load_we = 1'b0;
        wait_done(200);
        check("busy_load_wcount", 32'(recs.size() - base), 32'd2);
        if (recs.size() - base == 2) check_rec("busy_load", base + 1, tbl[1], 1);

        // Empty program
        base = recs.size(); d0 = done_cnt;
        prog_len = '0; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t2_done",  32'(done), 32'd1);
        check("t2_busy",  32'(busy), 32'd0);
        tick();
        @(negedge clk);
        check("t2_done_pulse", 32'(done), 32'd0);
        check("t2_no_w", 32'(recs.size() - base), 32'd0);
        tick();

        // Processor busy when ISSUE is entered
        load(0, tbl[2].word);
        hold_busy = 1'b1;
        tick(); tick();
        base = recs.size();
        prog_len = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("t3_w_held", 32'(recs.size() - base), 32'd0);
        check("t3_busy",   32'(busy), 32'd1);
        hold_busy = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (curr_state == 5'd0) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_release", 32'(found), 32'd1);
        check("t3_w_same_cycle", 32'(w), 32'd0);
        @(negedge clk);
        check("t3_w_next_cycle", 32'(w), 32'd1);
        check("t3_func", 32'(func), 32'(tbl[2].f));
        @(negedge clk);
        check("t3_w_one_cycle", 32'(w), 32'd0);
        wait_done(100);

        // Reset during WAIT_DONE of the second instruction
        for (int i = 0; i < 4; i++) load(i, tbl[i].word);
        base = recs.size(); d0 = done_cnt;
        prog_len = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (recs.size() == base + 2) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_second_w", 32'(found), 32'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t4_rst_w",    32'(w),    32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_done", 32'(done), 32'd0);
        check("t4_rst_pc",   32'(pc),   32'd0);
        check("t4_rst_word", {17'd0, func, rx, ry, data}, 32'd0);
        repeat (5) tick();
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_no_more_w", 32'(recs.size() - base), 32'd2);
        base = recs.size();
        run(4, 300);
        check("t4_restart_wcount", 32'(recs.size() - base), 32'd4);
        if (recs.size() - base == 4)
            for (int i = 0; i < 4; i++) check_rec("t4_restart", base + i, tbl[i], i);
        check("t4_restart_done", 32'(done_cnt - d0), 32'd1);

        // Processor never acknowledges
        load(0, tbl[1].word);
        stuck = 1'b1;
        base = recs.size(); d0 = done_cnt;
        prog_len = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (recs.size() > base) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_w_seen", 32'(found), 32'd1);
`ifdef WATCHDOG_EN
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (err) begin
                n = i;
                break;
            end
        end
        check("t5_wd_cycles", 32'(n), 32'd63);
        check("t5_wd_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", 32'(err), 32'd1);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
`else
        n = 0;
        repeat (100) @(negedge clk);
        check("t5_busy_held", 32'(busy), 32'd1);
        check("t5_err_zero", 32'(err), 32'd0);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
`endif
        stuck = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("t5_rst_err",  32'(err),  32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        tick();

        // Full-depth program, no wrap
        begin
            vec_t full[DEPTH];
            for (int i = 0; i < DEPTH; i++) begin
                full[i].f    = 3'(i % 8);
                full[i].x    = 4'(i);
                full[i].y    = 4'(15 - i);
                full[i].d    = 4'((3 * i) % 16);
                full[i].word = {full[i].f, full[i].x, full[i].y, full[i].d};
                load(i, full[i].word);
            end
            base = recs.size(); d0 = done_cnt;
            run(DEPTH, 800);
            check("t6_wcount", 32'(recs.size() - base), 32'(DEPTH));
            if (recs.size() - base == DEPTH)
                for (int i = 0; i < DEPTH; i++) check_rec("t6", base + i, full[i], i);
            check("t6_done_once", 32'(done_cnt - d0), 32'd1);
            @(negedge clk);
            check("t6_pc_final", 32'(pc), 32'd15);
            check("t6_busy_after", 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
